// File: rtl/clk_div_pkg.sv
// Shared constants and divisor helpers for the clk_div_prog divider family.
// The helpers are combinational only: no latency, no flow control.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 21;
  localparam int DEFAULT_DIV_DEF = 50000;

  function automatic int ch_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // A divisor below 2 has no room for both a high and a low phase, so it runs as 2.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

  function automatic logic [31:0] half_hi(input logic [31:0] d, input logic odd50);
    if (!d[0]) return d >> 1;
    return odd50 ? ((d - 32'd1) >> 1) : ((d + 32'd1) >> 1);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor, registered fout and tick (1 clk latency).
// Loads are taken whenever strobed (parent gates on !pending); ODD_DUTY50_EN adds a negedge duty-fix flop.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             pending,
  output logic             fout,
  output logic             tick
);

`ifdef ODD_DUTY50_EN
  localparam logic ODD50 = 1'b1;
`else
  localparam logic ODD50 = 1'b0;
`endif
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt, div, shadow, d_eff, hi;
  logic             wrap, restart, fout_pos;

  assign d_eff   = CNT_W'(eff_div(32'(div)));
  assign hi      = CNT_W'(half_hi(32'(d_eff), ODD50));
  assign wrap    = en && (cnt == d_eff - ONE);
  // A stopped channel is always at a period boundary, so a pending divisor may land at once.
  assign restart = !en || wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div      <= DIV_RST;
      shadow   <= DIV_RST;
      pending  <= 1'b0;
      fout_pos <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick     <= wrap;
      fout_pos <= en && (cnt < hi);
      cnt      <= restart ? '0 : cnt + ONE;
      if (load) begin
        shadow  <= load_div;
        pending <= 1'b1;
      end else if (pending && restart) begin
        div     <= shadow;
        pending <= 1'b0;
      end
    end
  end

`ifdef ODD_DUTY50_EN
  logic fout_neg;

  // Stretches the high phase by half a clock for odd divisors only.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) fout_neg <= 1'b0;
    else     fout_neg <= fout_pos && d_eff[0];
  end

  assign fout = fout_pos | fout_neg;
`else
  assign fout = fout_pos;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: per-channel fout/tick, 1 clk registered latency.
// Divisor loads use valid/ready; ready drops while the target channel holds an unapplied divisor.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           en,
  input  logic                          load_valid,
  input  logic [ch_idx_w(CHANNELS)-1:0] load_ch,
  input  logic [CNT_W-1:0]              load_div,
  output logic                          load_ready,
  output logic [CHANNELS-1:0]           fout,
  output logic [CHANNELS-1:0]           tick,
  output logic                          busy
);

  localparam int CH_W  = ch_idx_w(CHANNELS);
  localparam int SLOTS = 1 << CH_W;

  logic [CHANNELS-1:0] pending, load_hit;
  logic [SLOTS-1:0]    pend_slot;
  logic                in_range, accept;

  // Out-of-range channel numbers are always ready and silently dropped.
  assign pend_slot  = SLOTS'(pending);
  assign in_range   = (32'(load_ch) < CHANNELS);
  assign load_ready = in_range ? !pend_slot[load_ch] : 1'b1;
  assign accept     = load_valid && load_ready && in_range;
  assign busy       = |pending;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign load_hit[i] = accept && (load_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .load     (load_hit[i]),
      .load_div (load_div),
      .pending  (pending[i]),
      .fout     (fout[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random load/enable traffic against a timestamp model.
module tb_clk_div_prog;

  localparam int CH  = 2;
  localparam int CW  = 21;
  localparam int DEF = 50000;
`ifdef ODD_DUTY50_EN
  localparam bit ODD50 = 1'b1;
`else
  localparam bit ODD50 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          load_valid;
  logic [0:0]    load_ch;
  logic [CW-1:0] load_div;
  logic          load_ready;
  logic [CH-1:0] fout;
  logic [CH-1:0] tick;
  logic          busy;

  clk_div_prog #(
    .CHANNELS    (CH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_div   (load_div),
    .load_ready (load_ready),
    .fout       (fout),
    .tick       (tick),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each channel remembers the edge on which its current period began and the divisor in force.
  int     m_d[CH];
  int     m_sh[CH];
  bit     m_pend[CH];
  bit     m_fpos[CH];
  bit     m_fout[CH];
  bit     m_tick[CH];
  longint m_start[CH];
  longint edge_n = 0;

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int hi_time(input int d);
    if (d % 2 == 0) return d / 2;
    return ODD50 ? (d - 1) / 2 : (d + 1) / 2;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_d[c]     = DEF;
      m_sh[c]    = DEF;
      m_pend[c]  = 1'b0;
      m_fpos[c]  = 1'b0;
      m_fout[c]  = 1'b0;
      m_tick[c]  = 1'b0;
      m_start[c] = edge_n + 1;
    end
  endtask

  // One clock: drive at negedge, check handshake outputs, advance model at posedge, check at posedge+1.
  task automatic step(input logic [CH-1:0] e, input bit lv, input int lch, input int ldiv);
    bit acc;
    @(negedge clk);
    en         = e;
    load_valid = lv;
    load_ch    = 1'(lch);
    load_div   = CW'(ldiv);
    #1;
    chk("load_ready", 32'(load_ready), 32'(!m_pend[lch]));
    chk("busy", 32'(busy), 32'(m_pend[0] | m_pend[1]));
    acc = lv && !m_pend[lch];
    @(posedge clk);
    edge_n++;
    for (int c = 0; c < CH; c++) begin
      bit     prev_fpos;
      bit     prev_odd;
      longint rel;
      prev_fpos = m_fpos[c];
      prev_odd  = (m_d[c] % 2) == 1;
      if (!e[c]) begin
        m_tick[c]  = 1'b0;
        m_fpos[c]  = 1'b0;
        m_start[c] = edge_n + 1;
        if (m_pend[c]) begin
          m_d[c]    = m_sh[c];
          m_pend[c] = 1'b0;
        end
      end else begin
        rel       = edge_n - m_start[c];
        m_tick[c] = (rel == longint'(m_d[c] - 1));
        m_fpos[c] = (rel < longint'(hi_time(m_d[c])));
        if (m_tick[c]) begin
          m_start[c] = edge_n + 1;
          if (m_pend[c]) begin
            m_d[c]    = m_sh[c];
            m_pend[c] = 1'b0;
          end
        end
      end
      m_fout[c] = m_fpos[c] | (ODD50 && prev_fpos && prev_odd);
    end
    if (acc) begin
      m_sh[lch]   = eff(ldiv);
      m_pend[lch] = 1'b1;
    end
    #1;
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("tick%0d", c), 32'(tick[c]), 32'(m_tick[c]));
      chk($sformatf("fout%0d", c), 32'(fout[c]), 32'(m_fout[c]));
    end
  endtask

  // Half-clock sampler on channel 1 for duty-cycle measurement.
  bit meas = 1'b0;
  int half_hi_n = 0;
  always @(clk) begin
    if (meas) begin
      #2;
      if (fout[1] === 1'b1) half_hi_n++;
    end
  end

  initial begin
    int            first, second, ntick, nhi, nhi_old, b5, b6, ntog, n, t1a, t1b;
    int            t0_last, t0_prev;
    logic          prev;
    logic [CH-1:0] cur_en;

    rst        = 1'b1;
    en         = '0;
    load_valid = 1'b0;
    load_ch    = '0;
    load_div   = '0;
    #15;
    chk("rst_fout", 32'(fout), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(load_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // D=4 on channel 0
    step(2'b00, 1'b1, 0, 4);
    step(2'b00, 1'b0, 0, 0);
    first = 0; ntick = 0; nhi = 0;
    for (int i = 1; i <= 12; i++) begin
      step(2'b01, 1'b0, 0, 0);
      if (tick[0]) begin ntick++; if (first == 0) first = i; end
      if (fout[0]) nhi++;
    end
    chk("d4_first_tick", 32'(first), 32'(4));
    chk("d4_ticks", 32'(ntick), 32'(3));
    chk("d4_high", 32'(nhi), 32'(6));

    // D=5 on channel 1, high time in half clocks over two periods
    step(2'b00, 1'b1, 1, 5);
    step(2'b00, 1'b0, 0, 0);
    half_hi_n = 0; ntick = 0;
    meas = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(2'b10, 1'b0, 0, 0);
      if (tick[1]) ntick++;
    end
    meas = 1'b0;
    chk("d5_half_high", 32'(half_hi_n), ODD50 ? 32'(10) : 32'(12));
    chk("d5_ticks", 32'(ntick), 32'(2));

    // D=6 running, D=10 loaded at cnt=2
    step(2'b00, 1'b1, 0, 6);
    step(2'b00, 1'b0, 0, 0);
    first = 0; second = 0; nhi = 0; nhi_old = 0; b5 = 0; b6 = 0;
    for (int i = 1; i <= 16; i++) begin
      step(2'b01, (i == 3), 0, 10);
      if (tick[0]) begin if (first == 0) first = i; else if (second == 0) second = i; end
      if (fout[0]) begin if (i <= 6) nhi_old++; else nhi++; end
      if (i == 5) b5 = int'(busy);
      if (i == 6) b6 = int'(busy);
    end
    chk("d6_old_end", 32'(first), 32'(6));
    chk("d10_end", 32'(second), 32'(16));
    chk("d6_high", 32'(nhi_old), 32'(3));
    chk("d10_high", 32'(nhi), 32'(5));
    chk("busy_before_wrap", 32'(b5), 32'(1));
    chk("busy_after_wrap", 32'(b6), 32'(0));

    // Second load while pending is refused; the other channel still accepts
    step(2'b01, 1'b1, 0, 3);
    chk("reload_ready", 32'(load_ready), 32'(0));
    step(2'b01, 1'b1, 0, 7);
    step(2'b01, 1'b1, 1, 8);
    t1a = 0; t1b = 0; t0_last = 0; t0_prev = 0;
    for (int i = 1; i <= 24; i++) begin
      step(2'b11, 1'b0, 0, 0);
      if (tick[1]) begin if (t1a == 0) t1a = i; else if (t1b == 0) t1b = i; end
      if (tick[0]) begin t0_prev = t0_last; t0_last = i; end
    end
    chk("ch1_period8", 32'(t1b - t1a), 32'(8));
    chk("ch0_kept_first_load", 32'(t0_last - t0_prev), 32'(3));

    // Divisors 0 and 1 run as 2
    step(2'b00, 1'b1, 0, 0);
    step(2'b00, 1'b1, 1, 1);
    step(2'b00, 1'b0, 0, 0);
    ntick = 0; ntog = 0; n = 0; prev = fout[0];
    for (int i = 1; i <= 8; i++) begin
      step(2'b11, 1'b0, 0, 0);
      if (fout[0] !== prev) ntog++;
      prev = fout[0];
      if (tick[0]) ntick++;
      if (tick[1]) n++;
    end
    chk("d0_toggles", 32'(ntog), 32'(8));
    chk("d0_ticks", 32'(ntick), 32'(4));
    chk("d1_ticks", 32'(n), 32'(4));

    // Random enables and loads
    cur_en = 2'b11;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) cur_en[0] = ~cur_en[0];
      if ($urandom_range(15) == 0) cur_en[1] = ~cur_en[1];
      step(cur_en, ($urandom_range(3) == 0), int'($urandom_range(1)), int'($urandom_range(12)));
    end

    // Asynchronous reset while an output is high
    step(2'b11, 1'b1, 0, 9);
    for (int i = 0; i < 40; i++) begin
      if (fout != '0) break;
      step(2'b11, 1'b0, 0, 0);
    end
    chk("pre_rst_active", 32'(fout != '0), 32'(1));
    #4;
    rst = 1'b1;
    #1;
    chk("async_fout", 32'(fout), 32'(0));
    chk("async_tick", 32'(tick), 32'(0));
    chk("async_busy", 32'(busy), 32'(0));
    en = '0;
    load_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Default divisor after reset release
    n = 0; nhi = 0;
    while (n < 60000) begin
      step(2'b01, 1'b0, 0, 0);
      n++;
      if (fout[0]) nhi++;
      if (tick[0]) break;
    end
    chk("def_first_tick", 32'(n), 32'(DEF));
    chk("def_high", 32'(nhi), 32'(DEF / 2));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
